// File: rtl/ds_sample_interpolator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ds_sample_interpolator                                                     |
// | Sample FIFO feeding a delta-sigma modulator u input, one sample per        |
// | 2^interp_log2 steps. DS_INTERP_LINEAR_EN: linear ramp, else zero-order hold.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ds_sample_interpolator #(
  parameter int IN_BITS    = 16,
  parameter int LOG2_BITS  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IN_BITS-1:0]            in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          step,
  input  logic [LOG2_BITS-1:0]          interp_log2,
  output logic [IN_BITS-1:0]            u,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);
  localparam int MAX_LOG2 = (1 << LOG2_BITS) - 1;
  localparam int ACC_W    = IN_BITS + 1 + MAX_LOG2;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic [0:0] {S_HOLD = 1'b0, S_RUN = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic [IN_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wp, r_rp;
  logic [CNT_W-1:0]     r_count;
  logic [IN_BITS-1:0]   r_tgt, w_tgt_nxt, w_head;
  logic [ACC_W-1:0]     r_acc, w_acc_nxt, r_inc, w_inc_nxt;
  logic [ACC_W-1:0]     w_load_acc, w_load_inc, w_tgt_scaled;
  logic [MAX_LOG2-1:0]  r_phase, w_phase_nxt, w_last;
  logic [LOG2_BITS-1:0] r_l_cur, w_l_cur_nxt;
  logic                 r_underrun, w_underrun_nxt;
  logic                 w_empty, w_push, w_pop;

  assign w_empty      = (r_count == '0);
  assign in_ready     = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push       = in_valid && in_ready;
  assign w_head       = r_mem[r_rp];
  assign w_tgt_scaled = {1'b0, r_tgt, {MAX_LOG2{1'b0}}};
  assign w_last       = (MAX_LOG2'(1) << r_l_cur) - MAX_LOG2'(1);

`ifdef DS_INTERP_LINEAR_EN
  logic [IN_BITS:0]     w_delta;
  logic [LOG2_BITS-1:0] w_shamt;
  // Scaling the delta by 2^(MAX_LOG2-l) lets 2^l increments land exactly on the target.
  assign w_delta    = {1'b0, w_head} - {1'b0, r_tgt};
  assign w_shamt    = LOG2_BITS'(MAX_LOG2) - interp_log2;
  assign w_load_inc = {{MAX_LOG2{w_delta[IN_BITS]}}, w_delta} << w_shamt;
  assign w_load_acc = w_tgt_scaled;
`else
  assign w_load_inc = '0;
  assign w_load_acc = {1'b0, w_head, {MAX_LOG2{1'b0}}};
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_inc_nxt      = r_inc;
    w_tgt_nxt      = r_tgt;
    w_phase_nxt    = r_phase;
    w_l_cur_nxt    = r_l_cur;
    w_underrun_nxt = r_underrun;
    w_pop          = 1'b0;
    case (r_state)
      S_HOLD: w_pop = !w_empty;
      S_RUN: begin
        if (step) begin
          if (r_phase != w_last) begin
            w_acc_nxt   = r_acc + r_inc;
            w_phase_nxt = r_phase + MAX_LOG2'(1);
          end else begin
            w_acc_nxt = w_tgt_scaled;
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_underrun_nxt = 1'b1;
              w_state_nxt    = S_HOLD;
            end
          end
        end
      end
      default: w_state_nxt = S_HOLD;
    endcase
    if (w_pop) begin
      w_acc_nxt   = w_load_acc;
      w_inc_nxt   = w_load_inc;
      w_tgt_nxt   = w_head;
      w_phase_nxt = '0;
      w_l_cur_nxt = interp_log2;
      w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_HOLD;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_tgt      <= '0;
      r_acc      <= '0;
      r_inc      <= '0;
      r_phase    <= '0;
      r_l_cur    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt      <= w_tgt_nxt;
      r_acc      <= w_acc_nxt;
      r_inc      <= w_inc_nxt;
      r_phase    <= w_phase_nxt;
      r_l_cur    <= w_l_cur_nxt;
      r_underrun <= w_underrun_nxt;
      if (w_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop)  r_rp <= r_rp + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign u          = r_acc[MAX_LOG2+IN_BITS-1:MAX_LOG2];
  assign fifo_level = r_count;
  assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ds_sample_interpolator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ds_sample_interpolator                                                  |
// | Directed and random stimulus against a segment-level reference model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ds_sample_interpolator;
  localparam int IN_BITS    = 16;
  localparam int LOG2_BITS  = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 r_reset, r_in_valid, r_step;
  logic [IN_BITS-1:0]   r_in_data;
  logic [LOG2_BITS-1:0] r_interp;
  logic                 w_in_ready, w_underrun;
  logic [IN_BITS-1:0]   w_u;
  logic [LVL_W-1:0]     w_level;

  ds_sample_interpolator #(
    .IN_BITS(IN_BITS), .LOG2_BITS(LOG2_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(r_reset), .in_data(r_in_data), .in_valid(r_in_valid),
    .in_ready(w_in_ready), .step(r_step), .interp_log2(r_interp), .u(w_u),
    .fifo_level(w_level), .underrun(w_underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: sample queue plus the current segment (prev -> tgt over 2^l steps, k steps taken).
  int q[$];
  int m_prev, m_tgt, m_l, m_k;
  bit m_run, m_und;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_u();
    if (!m_run) return m_tgt;
`ifdef DS_INTERP_LINEAR_EN
    return (m_prev * (1 << m_l) + m_k * (m_tgt - m_prev)) / (1 << m_l);
`else
    return m_tgt;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_prev = 0; m_tgt = 0; m_l = 0; m_k = 0; m_run = 0; m_und = 0;
  endtask

  task automatic model_load(input int il);
    m_prev = m_tgt;
    m_tgt  = q.pop_front();
    m_l    = il;
    m_k    = 0;
    m_run  = 1;
  endtask

  task automatic cycle(input bit rst, input bit v, input int d, input bit st, input int il,
                       output bit accd);
    int pre;
    r_reset = rst; r_in_valid = v; r_in_data = IN_BITS'(d); r_step = st;
    r_interp = LOG2_BITS'(il);
    @(posedge clk);
    accd = 0;
    if (rst) begin
      model_reset();
    end else begin
      pre  = q.size();
      accd = v && (pre < FIFO_DEPTH);
      if (!m_run) begin
        if (pre > 0) model_load(il);
      end else if (st) begin
        if (m_k != (1 << m_l) - 1) m_k++;
        else if (pre > 0) model_load(il);
        else begin m_run = 0; m_und = 1; end
      end
      if (accd) q.push_back(d & 16'hFFFF);
    end
    #1;
    chk("u", w_u, exp_u());
    chk("fifo_level", w_level, q.size());
    chk("in_ready", w_in_ready, (q.size() < FIFO_DEPTH));
    chk("underrun", w_underrun, m_und);
  endtask

  initial begin
    bit a;
    int acc_cnt, idx, il;
    int up_tbl[9] = '{'h0, 'h400, 'h800, 'hC00, 'h1000, 'h1400, 'h1800, 'h1C00, 'h2000};
    model_reset();
    r_reset = 1; r_in_valid = 0; r_in_data = 0; r_step = 0; r_interp = 0;

    cycle(1, 0, 0, 0, 2, a);
    cycle(1, 1, 'h55, 1, 2, a);
    chk("rst_u", w_u, 0);
    chk("rst_ready", w_in_ready, 1);

    // Ramp up 0 -> 0x1000 -> 0x2000
    cycle(0, 1, 'h1000, 0, 2, a);
    cycle(0, 1, 'h2000, 0, 2, a);
    cycle(0, 0, 0, 0, 2, a);
`ifdef DS_INTERP_LINEAR_EN
    chk("ramp_up_0", w_u, up_tbl[0]);
`endif
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 1, 2, a);
`ifdef DS_INTERP_LINEAR_EN
      chk("ramp_up_seq", w_u, up_tbl[i+1]);
`endif
    end
    cycle(0, 0, 0, 1, 2, a);
    chk("ramp_up_end_u", w_u, 'h2000);
    chk("ramp_up_underrun", w_underrun, 1);

    // Ramp down with floor rounding
    cycle(0, 1, 'h1FFD, 0, 2, a);
    cycle(0, 0, 0, 0, 2, a);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 2, a);
    chk("ramp_down_end", w_u, 'h1FFD);

    // Backpressure with a held in_valid
    cycle(1, 0, 0, 0, 2, a);
    acc_cnt = 0; idx = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 'hA000 + idx, 0, 2, a);
      if (a) begin acc_cnt++; idx++; end
    end
    chk("bp_accepted", acc_cnt, 5);
    chk("bp_ready", w_in_ready, 0);
    chk("bp_level", w_level, 4);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 'hA000 + idx, (i < 4), 2, a);
      if (a) begin acc_cnt++; idx++; end
    end
    chk("bp_one_more", acc_cnt, 6);
    for (int i = 0; i < 26; i++) cycle(0, 0, 0, 1, 2, a);
    chk("bp_drained_u", w_u, 'hA005);

    // interp_log2 change mid-segment
    cycle(1, 0, 0, 0, 3, a);
    cycle(0, 1, 'h0800, 0, 3, a);
    cycle(0, 1, 'h1800, 0, 3, a);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 1, 1, a);
      if (i == 7) chk("l2_seg1_len", w_underrun, 0);
      if (i == 8) chk("l2_seg2_mid", w_underrun, 0);
    end
    chk("l2_seg2_end", w_underrun, 1);
    chk("l2_final_u", w_u, 'h1800);

    // Reset mid-segment with samples queued
    cycle(0, 1, 'h0100, 0, 3, a);
    cycle(0, 1, 'h0300, 0, 3, a);
    cycle(0, 1, 'h0500, 0, 3, a);
    cycle(0, 0, 0, 1, 3, a);
    cycle(0, 0, 0, 1, 3, a);
    cycle(1, 1, 'h0700, 1, 3, a);
    chk("mid_rst_u", w_u, 0);
    chk("mid_rst_level", w_level, 0);
    chk("mid_rst_underrun", w_underrun, 0);
    chk("mid_rst_ready", w_in_ready, 1);

    // Random traffic
    il = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) il = $urandom_range(0, 3);
      cycle(0, $urandom_range(0, 2) == 0, $urandom_range(0, 'hFFFF),
            $urandom_range(0, 1), il, a);
    end
    cycle(1, 0, 0, 0, 0, a);
    chk("final_rst_u", w_u, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
